// File: rtl/ram8_bank.sv
// Eight 16-bit words with combinational read, self-clearing sweep after reset/clear, ready flag, dirty mask.
// Optional write-through forward of the write data when RAM8_BYPASS_EN is defined.

module mux8way16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_c,
  input  logic [15:0] i_d,
  input  logic [15:0] i_e,
  input  logic [15:0] i_f,
  input  logic [15:0] i_g,
  input  logic [15:0] i_h,
  input  logic [2:0]  i_sel,
  output logic [15:0] o_out
);
  always_comb begin
    o_out = i_a;
    case (i_sel)
      3'd0: o_out = i_a;
      3'd1: o_out = i_b;
      3'd2: o_out = i_c;
      3'd3: o_out = i_d;
      3'd4: o_out = i_e;
      3'd5: o_out = i_f;
      3'd6: o_out = i_g;
      3'd7: o_out = i_h;
      default: o_out = i_a;
    endcase
  end
endmodule

module ram8_bank #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic        clear,
  output logic [15:0] out,
  output logic        ready,
  output logic [7:0]  dirty
);
  localparam logic S_CLEAR = 1'b0;
  localparam logic S_IDLE  = 1'b1;

  logic        r_state;
  logic [2:0]  r_sweep_idx;
  logic [7:0]  r_dirty;
  logic [15:0] r_word [0:7];

  logic        w_ready;
  logic        w_do_clear;
  logic        w_do_load;
  logic [15:0] w_mux_out;

  assign w_ready    = (r_state == S_IDLE);
  assign w_do_clear = w_ready && clear;
  // clear has priority over load in the same cycle
  assign w_do_load  = w_ready && !clear && load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_sweep_idx <= 3'd0;
      r_dirty     <= 8'h00;
    end else if (r_state == S_CLEAR) begin
      r_sweep_idx <= r_sweep_idx + 3'd1;
      if (r_sweep_idx == 3'd7) begin
        r_state <= S_IDLE;
      end
    end else if (w_do_clear) begin
      r_state     <= S_CLEAR;
      r_sweep_idx <= 3'd0;
      r_dirty     <= 8'h00;
    end else if (w_do_load) begin
      r_dirty[address] <= 1'b1;
    end
  end

  // Storage is not reset; the sweep initialises it and out is gated until then
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == S_CLEAR) begin
        r_word[r_sweep_idx] <= CLEAR_VALUE;
      end else if (w_do_load) begin
        r_word[address] <= in;
      end
    end
  end

  mux8way16 u_mux (
    .i_a   (r_word[0]),
    .i_b   (r_word[1]),
    .i_c   (r_word[2]),
    .i_d   (r_word[3]),
    .i_e   (r_word[4]),
    .i_f   (r_word[5]),
    .i_g   (r_word[6]),
    .i_h   (r_word[7]),
    .i_sel (address),
    .o_out (w_mux_out)
  );

`ifdef RAM8_BYPASS_EN
  assign out = !w_ready ? 16'h0000 : (load ? in : w_mux_out);
`else
  assign out = w_ready ? w_mux_out : 16'h0000;
`endif

  assign ready = w_ready;
  assign dirty = r_dirty;
endmodule
